pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
// PURPOSE
//  Programmable square-wave/pulse-train source; transmit-side counterpart of the edge-counting timer.
//  Drives signal_out with a known period/high-time so the frequency counter can be checked in-system.
//  Config is loaded via a valid/ready handshake and applied glitch-free at period boundaries.
//  Sits beside the counter on the lab board; signal_out feeds the counter's clock (signal) input.
// PARAMETERS
//  WIDTH       32  width of period/high/burst fields and pulse_count
//  MIN_PERIOD  2   smallest period applied; smaller requests are clamped up to this
// PORTS
//  clock        in   1      system clock; all logic on posedge
//  reset        in   1      asynchronous, active-low reset
//  enable       in   1      run request: 1 = generate, 0 = stop at the end of the current period
//  load_valid   in   1      config offered this cycle
//  load_ready   out  1      config can be accepted (no update pending)
//  period_in    in   WIDTH  period in clock cycles
//  high_in      in   WIDTH  high time in clock cycles
//  burst_in     in   WIDTH  periods per burst; 0 = continuous
//  signal_out   out  1      generated waveform, registered
//  busy         out  1      1 while in RUN
//  done         out  1      one-cycle pulse on burst completion
//  pulse_count  out  WIDTH  completed periods since entering RUN; saturates at all-ones
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, phase=0, pending=0, cfg_valid=0, active cfg=0,
//   signal_out=0, busy=0, done=0, pulse_count=0, load_ready=1.
//  Handshake: transfer when load_valid && load_ready. load_ready = !pending.
//   IDLE: transfer writes the active cfg directly and sets cfg_valid; pending stays 0.
//   RUN: transfer writes the shadow cfg and sets pending=1; the shadow moves to active on the next
//   period boundary, and pending clears on that same edge.
//  Clamp at capture: period_eff = max(period_in, MIN_PERIOD). high=0 -> constant low;
//   high >= period_eff -> constant high. Both count as normal periods.
//  FSM: IDLE -> RUN when enable && cfg_valid. RUN -> IDLE at a boundary when !enable.
//   RUN -> DONE at the boundary that completes burst periods (burst != 0). DONE -> IDLE after 1 cycle.
//  Entry edge (IDLE->RUN): phase=0, pulse_count=0, busy=1, signal_out=(high>0).
//   First high cycle is the cycle after enable is sampled.
//  RUN each edge: boundary = (phase == period_eff-1). On a boundary, phase=0; otherwise phase=phase+1.
//   signal_out = (next_phase < high). On a boundary, pulse_count = pulse_count+1 (saturating)
//   and the pending cfg is applied, so the new period starts with the new values.
//  Burst end: on the boundary where pulse_count+1 == burst, go to DONE, assert done for 1 cycle,
//   and set signal_out=0, busy=0. pulse_count holds until the next RUN entry.
//  Stop: enable low mid-period -> the period finishes; IDLE on the boundary; signal_out=0. No runt pulses.
//  Simultaneous: a load accepted on a boundary edge goes to the shadow, applied at the next boundary.
//   enable=0 together with a burst-final boundary -> DONE takes priority (done pulses).
//  Arithmetic: unsigned WIDTH-bit compares; phase is WIDTH bits and never exceeds period_eff-1.
//  Reset mid-operation: output low immediately; config lost; reload is required before the next run.
// CONFIGURATION
//  GEN_BURST_EN defined: burst_in honoured; DONE state and done pulse as above.
//  GEN_BURST_EN undefined: burst_in ignored (always continuous), DONE state absent, done tied 0.
//   Port list is unchanged.
// TESTING
//  1 Load p=4,h=2,b=0; enable=1 -> signal_out 1,1,0,0 repeating from cycle after enable;
//    pulse_count +1 every 4 cycles.
//  2 Load p=3,h=1,b=3; enable -> exactly 3 pulses; done=1 for one cycle 9 cycles after entry;
//    busy=0; pulse_count=3 (burst build only).
//  3 Run p=4,h=2; load p=6,h=1 mid-period -> load_ready=0 until boundary;
//    next period 1,0,0,0,0,0; load_ready back to 1.
//  4 Load p=1,h=0 then p=5,h=9 -> clamp to period 2, constant low;
//    then constant high; pulse_count still increments per period.
//  5 Drop enable at phase 1 of p=8,h=4 -> waveform completes 8 cycles, then IDLE, signal_out=0, busy=0.
//  6 Assert reset mid-high -> signal_out=0 same cycle; enable without reload keeps IDLE.

Source files
------------

// File: rtl/pulse_train_gen.sv
// pulse_train_gen
//   Programmable square-wave / pulse-train source. A configuration (period,
//   high time, burst length) is loaded through a valid/ready handshake. While
//   running, a new configuration waits in a shadow register and becomes active
//   only at a period boundary, so the waveform never glitches.
//
//   Build option: define GEN_BURST_EN to honour burst_in (DONE state and done
//   pulse). Without it, burst_in is ignored, generation is always continuous,
//   and done is tied low. The port list is identical in both builds.
//
// Handshake: a config word transfers on a rising clock edge where
//   load_valid && load_ready. load_ready is low only while a shadow update is
//   pending; the offered fields are sampled on the transfer edge only.
//
// Ports
//   clock        in   1      system clock, posedge
//   reset        in   1      asynchronous, active-low reset
//   enable       in   1      run request; 0 stops at the end of the current period
//   load_valid   in   1      config offered
//   load_ready   out  1      config can be accepted (no update pending)
//   period_in    in   WIDTH  period in clock cycles (clamped up to MIN_PERIOD)
//   high_in      in   WIDTH  high time in clock cycles
//   burst_in     in   WIDTH  periods per burst, 0 = continuous
//   signal_out   out  1      generated waveform, registered
//   busy         out  1      high while running
//   done         out  1      one-cycle pulse when a burst completes
//   pulse_count  out  WIDTH  completed periods since the run started, saturating
module pulse_train_gen #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MIN_PERIOD = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] high_in,
    input  logic [WIDTH-1:0] burst_in,
    output logic             signal_out,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pulse_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] MIN_P = WIDTH'(MIN_PERIOD);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    state_t           state, state_nx;
    logic [WIDTH-1:0] phase, phase_nx;
    logic [WIDTH-1:0] count_nx;
    logic             sig_nx, done_nx;
    logic             cfg_valid, cfg_valid_nx;
    logic             pending, pending_nx;
    logic [WIDTH-1:0] act_period, act_period_nx, act_high, act_high_nx;
    logic [WIDTH-1:0] sh_period, sh_period_nx, sh_high, sh_high_nx;

    logic             xfer;
    logic             boundary;
    logic [WIDTH-1:0] cap_period;
    logic [WIDTH-1:0] phase_inc;
    logic [WIDTH-1:0] count_inc;

    assign load_ready = !pending;
    assign busy       = (state == S_RUN);
    assign xfer       = load_valid && load_ready;
    assign cap_period = (period_in < MIN_P) ? MIN_P : period_in;
    assign phase_inc  = phase + ONE;
    assign count_inc  = (pulse_count == '1) ? pulse_count : pulse_count + ONE;
    // Active period is always >= MIN_PERIOD while running, so the subtract cannot wrap there.
    assign boundary   = (phase == act_period - ONE);

`ifdef GEN_BURST_EN
    logic [WIDTH-1:0] act_burst, act_burst_nx, sh_burst, sh_burst_nx;
    logic             burst_hit;
    assign burst_hit = (act_burst != '0) && ((pulse_count + ONE) == act_burst);
`else
    logic unused_burst;
    assign unused_burst = ^burst_in;
`endif

    always_comb begin
        state_nx      = state;
        phase_nx      = phase;
        count_nx      = pulse_count;
        sig_nx        = signal_out;
        done_nx       = 1'b0;
        cfg_valid_nx  = cfg_valid;
        pending_nx    = pending;
        act_period_nx = act_period;
        act_high_nx   = act_high;
        sh_period_nx  = sh_period;
        sh_high_nx    = sh_high;
`ifdef GEN_BURST_EN
        act_burst_nx  = act_burst;
        sh_burst_nx   = sh_burst;
`endif
        case (state)
            S_IDLE: begin
                sig_nx = 1'b0;
                if (xfer) begin
                    act_period_nx = cap_period;
                    act_high_nx   = high_in;
`ifdef GEN_BURST_EN
                    act_burst_nx  = burst_in;
`endif
                    cfg_valid_nx  = 1'b1;
                end
                if (enable && cfg_valid) begin
                    state_nx = S_RUN;
                    phase_nx = '0;
                    count_nx = '0;
                    sig_nx   = (act_high_nx != '0);
                end
            end
            S_RUN: begin
                if (boundary) begin
                    phase_nx = '0;
                    count_nx = count_inc;
                    // Shadow takes effect here so the next period starts with the new values.
                    if (pending) begin
                        act_period_nx = sh_period;
                        act_high_nx   = sh_high;
`ifdef GEN_BURST_EN
                        act_burst_nx  = sh_burst;
`endif
                        pending_nx    = 1'b0;
                    end
`ifdef GEN_BURST_EN
                    // Burst completion outranks a stop request.
                    if (burst_hit) begin
                        state_nx = S_DONE;
                        done_nx  = 1'b1;
                        sig_nx   = 1'b0;
                    end else
`endif
                    if (!enable) begin
                        state_nx = S_IDLE;
                        sig_nx   = 1'b0;
                    end else begin
                        sig_nx = (act_high_nx != '0);
                    end
                end else begin
                    phase_nx = phase_inc;
                    sig_nx   = (phase_inc < act_high);
                end
                // Pending and xfer are mutually exclusive, so this never races the apply above.
                if (xfer) begin
                    sh_period_nx = cap_period;
                    sh_high_nx   = high_in;
`ifdef GEN_BURST_EN
                    sh_burst_nx  = burst_in;
`endif
                    pending_nx   = 1'b1;
                end
            end
`ifdef GEN_BURST_EN
            S_DONE: begin
                sig_nx   = 1'b0;
                state_nx = S_IDLE;
                if (xfer) begin
                    act_period_nx = cap_period;
                    act_high_nx   = high_in;
                    act_burst_nx  = burst_in;
                    cfg_valid_nx  = 1'b1;
                end
            end
`endif
            default: begin
                state_nx = S_IDLE;
                sig_nx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            phase       <= '0;
            pulse_count <= '0;
            signal_out  <= 1'b0;
            done        <= 1'b0;
            cfg_valid   <= 1'b0;
            pending     <= 1'b0;
            act_period  <= '0;
            act_high    <= '0;
            sh_period   <= '0;
            sh_high     <= '0;
`ifdef GEN_BURST_EN
            act_burst   <= '0;
            sh_burst    <= '0;
`endif
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            pulse_count <= count_nx;
            signal_out  <= sig_nx;
            done        <= done_nx;
            cfg_valid   <= cfg_valid_nx;
            pending     <= pending_nx;
            act_period  <= act_period_nx;
            act_high    <= act_high_nx;
            sh_period   <= sh_period_nx;
            sh_high     <= sh_high_nx;
`ifdef GEN_BURST_EN
            act_burst   <= act_burst_nx;
            sh_burst    <= sh_burst_nx;
`endif
        end
    end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen. Stimulus is applied on the falling edge; the
// reference model predicts the outputs after the following rising edge and
// pushes them into exp_q. A monitor pops one entry per rising edge and
// compares. The model describes each period as a list of levels (high cycles
// followed by low cycles) and consumes one level per clock.
module tb_pulse_train_gen;

    localparam int W    = 16;
    localparam int MINP = 2;
`ifdef GEN_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] period_in = '0;
    logic [W-1:0] high_in = '0;
    logic [W-1:0] burst_in = '0;
    logic         load_ready, signal_out, busy, done;
    logic [W-1:0] pulse_count;

    pulse_train_gen #(.WIDTH(W), .MIN_PERIOD(MINP)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .period_in   (period_in),
        .high_in     (high_in),
        .burst_in    (burst_in),
        .signal_out  (signal_out),
        .busy        (busy),
        .done        (done),
        .pulse_count (pulse_count)
    );

    // clock / reset
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [W+3:0] exp_q[$];

    // reference model: mode 0 idle, 1 running, 2 burst finished
    int          m_mode;
    bit          m_cfg_valid, m_pending, m_sig, m_done;
    int unsigned m_p, m_h, m_b, s_p, s_h, s_b;
    int unsigned m_count;
    bit          wave[$];

    function automatic void m_reset();
        m_mode = 0; m_cfg_valid = 0; m_pending = 0; m_sig = 0; m_done = 0;
        m_p = 0; m_h = 0; m_b = 0; s_p = 0; s_h = 0; s_b = 0; m_count = 0;
        wave.delete();
    endfunction

    function automatic void fill_wave();
        wave.delete();
        for (int i = 0; i < int'(m_p); i++) wave.push_back(i < int'(m_h));
    endfunction

    function automatic void model_step(bit en, bit lv, int unsigned p, int unsigned h, int unsigned b);
        bit          xfer;
        int unsigned pc;
        bit          was_valid;
        int unsigned burst_now;
        xfer      = lv && !m_pending;
        pc        = (p < MINP) ? MINP : p;
        was_valid = m_cfg_valid;
        m_done    = 0;
        if (m_mode == 0) begin
            if (xfer) begin m_p = pc; m_h = h; m_b = b; m_cfg_valid = 1; end
            if (en && was_valid) begin
                m_mode = 1; m_count = 0; fill_wave(); m_sig = wave.pop_front();
            end else m_sig = 0;
        end else if (m_mode == 1) begin
            if (wave.size() == 0) begin
                burst_now = m_b;
                if (m_count != (32'd1 << W) - 1) m_count++;
                if (m_pending) begin m_p = s_p; m_h = s_h; m_b = s_b; m_pending = 0; end
                if (BURST_ON && burst_now != 0 && m_count == burst_now) begin
                    m_mode = 2; m_done = 1; m_sig = 0;
                end else if (!en) begin
                    m_mode = 0; m_sig = 0;
                end else begin
                    fill_wave(); m_sig = wave.pop_front();
                end
            end else m_sig = wave.pop_front();
            if (xfer) begin s_p = pc; s_h = h; s_b = b; m_pending = 1; end
        end else begin
            if (xfer) begin m_p = pc; m_h = h; m_b = b; m_cfg_valid = 1; end
            m_mode = 0; m_sig = 0;
        end
        exp_q.push_back({!m_pending, (m_mode == 1), m_done, m_sig, W'(m_count)});
    endfunction

    // driver tasks
    task automatic drive(bit en, bit lv, int unsigned p, int unsigned h, int unsigned b);
        @(negedge clock);
        enable     = en;
        load_valid = lv;
        period_in  = W'(p);
        high_in    = W'(h);
        burst_in   = W'(b);
        model_step(en, lv, p, h, b);
    endtask

    task automatic run(int n);
        repeat (n) drive(1'b1, 1'b0, 0, 0, 0);
    endtask

    task automatic idle_wait(int n);
        repeat (n) drive(1'b0, 1'b0, 0, 0, 0);
    endtask

    task automatic check(string name, logic [W+3:0] got, logic [W+3:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
        end
    endtask

    task automatic reset_mid();
        @(negedge clock);
        #2 reset = 1'b0;
        #1 check("reset_async", {load_ready, busy, done, signal_out, pulse_count}, {1'b1, 3'b000, W'(0)});
        m_reset();
        load_valid = 1'b0;
        enable     = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    // scoreboard monitor
    always @(posedge clock) begin
        logic [W+3:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("cycle", {load_ready, busy, done, signal_out, pulse_count}, e);
        end
    end

    initial begin
        m_reset();
        repeat (2) @(negedge clock);
        check("reset_init", {load_ready, busy, done, signal_out, pulse_count}, {1'b1, 3'b000, W'(0)});
        reset = 1'b1;

        // continuous 4/2
        drive(1'b0, 1'b1, 4, 2, 0);
        run(13);
        idle_wait(10);

        // burst of three 3/1 periods
        drive(1'b0, 1'b1, 3, 1, 3);
        run(14);
        idle_wait(10);

        // reconfigure mid-period
        drive(1'b0, 1'b1, 4, 2, 0);
        run(6);
        drive(1'b1, 1'b1, 6, 1, 0);
        run(16);
        idle_wait(10);

        // clamp to minimum period, then high >= period
        drive(1'b0, 1'b1, 1, 0, 0);
        run(7);
        drive(1'b1, 1'b1, 5, 9, 0);
        run(14);
        idle_wait(10);

        // stop request early in a long period
        drive(1'b0, 1'b1, 8, 4, 0);
        run(2);
        idle_wait(12);

        // reset while high, then enable without reloading
        drive(1'b0, 1'b1, 4, 4, 0);
        run(3);
        reset_mid();
        run(6);
        idle_wait(2);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 19) != 0), ($urandom_range(0, 4) == 0),
                  $urandom_range(0, 7), $urandom_range(0, 9), $urandom_range(0, 4));
        end
        idle_wait(12);

        @(posedge clock);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
